// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
//   ArbState  : IDLE -> ACCESS -> RESP sequencing of one memory access
//   ArbOwner  : which requester owns the bus for the current access
//   INST_NOP  : value presented on the fetch data port out of reset
//   cnt_width : width of the wait-state counter for a given WAIT_STATES
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} ArbState;
  typedef enum logic {OWNER_INST, OWNER_DATA} ArbOwner;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // max(1, clog2(ws+1)): the counter only has to reach WAIT_STATES, since it
  // is cleared on every grant.
  function automatic int cnt_width(input int ws);
    return (ws < 1) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_wait_counter.sv
// Wait-state counter for one memory access.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   clear  : restart the count at 0 (asserted on grant)
//   enable : advance the count (asserted during ACCESS)
//   done   : count has reached WAIT_STATES (last ACCESS cycle)
module arb_wait_counter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CW = cnt_width(WAIT_STATES);

  logic [CW-1:0] cnt;

  // Holds at the terminal count so a stray enable can never wrap it.
  always_ff @(posedge clk) begin
    if (!rst_n)                cnt <= '0;
    else if (clear)            cnt <= '0;
    else if (enable && !done)  cnt <= cnt + 1'b1;
  end

  assign done = (cnt == CW'(WAIT_STATES));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch (IF) and
// data access (MEM). Each access runs WAIT_STATES+1 ACCESS cycles, then a
// one-cycle RESP cycle carrying the owner's ack. All outputs are registered.
// Optional feature macro: ARB_FAIRNESS_EN
//   undefined : fixed priority, DATA wins a simultaneous request
//   defined   : simultaneous requests alternate, starting from whoever was
//               not granted last
// Ports:
//   i_Clock, i_Reset                     : clock, synchronous active-low reset
//   i_InstReq/i_InstAddr                 : fetch request, held until o_InstAck
//   o_InstData/o_InstAck                 : fetched word, one-cycle ack pulse
//   i_DataReq/i_DataWrEnable/i_DataAddr/
//   i_DataWrData                         : load/store request, held until o_DataAck
//   o_DataRdData/o_DataAck               : load data, one-cycle ack pulse
//   o_MemAddr/o_MemWrEnable/o_MemWrData  : memory command
//   i_MemRdData                          : memory read data (valid last ACCESS cycle)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_InstReq,
  input  logic [ADDR_WIDTH-1:0] i_InstAddr,
  output logic [DATA_WIDTH-1:0] o_InstData,
  output logic                  o_InstAck,
  input  logic                  i_DataReq,
  input  logic                  i_DataWrEnable,
  input  logic [ADDR_WIDTH-1:0] i_DataAddr,
  input  logic [DATA_WIDTH-1:0] i_DataWrData,
  output logic [DATA_WIDTH-1:0] o_DataRdData,
  output logic                  o_DataAck,
  output logic [ADDR_WIDTH-1:0] o_MemAddr,
  output logic                  o_MemWrEnable,
  output logic [DATA_WIDTH-1:0] o_MemWrData,
  input  logic [DATA_WIDTH-1:0] i_MemRdData
);

  ArbState state, state_nxt;
  ArbOwner owner, owner_nxt, pick;
  logic    grant, done;

  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt, inst_data_nxt, rd_data_nxt;
  logic                  we_nxt, inst_ack_nxt, data_ack_nxt;

`ifdef ARB_FAIRNESS_EN
  ArbOwner last_owner;

  always_comb begin
    if (i_InstReq && i_DataReq)
      pick = (last_owner == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
    else if (i_DataReq)
      pick = OWNER_DATA;
    else
      pick = OWNER_INST;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset)   last_owner <= OWNER_INST;
    else if (grant) last_owner <= pick;
  end
`else
  assign pick = i_DataReq ? OWNER_DATA : OWNER_INST;
`endif

  arb_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .clk    (i_Clock),
    .rst_n  (i_Reset),
    .clear  (grant),
    .enable (state == ARB_ACCESS),
    .done   (done)
  );

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    addr_nxt      = o_MemAddr;
    wdata_nxt     = o_MemWrData;
    we_nxt        = o_MemWrEnable;
    inst_data_nxt = o_InstData;
    rd_data_nxt   = o_DataRdData;
    inst_ack_nxt  = 1'b0;
    data_ack_nxt  = 1'b0;
    grant         = 1'b0;
    case (state)
      ARB_IDLE: begin
        we_nxt = 1'b0;
        if (i_InstReq || i_DataReq) begin
          grant     = 1'b1;
          owner_nxt = pick;
          state_nxt = ARB_ACCESS;
          if (pick == OWNER_DATA) begin
            addr_nxt  = i_DataAddr;
            wdata_nxt = i_DataWrData;
            we_nxt    = i_DataWrEnable;
          end else begin
            addr_nxt  = i_InstAddr;
          end
        end
      end
      ARB_ACCESS: begin
        if (done) begin
          we_nxt    = 1'b0;
          state_nxt = ARB_RESP;
          if (owner == OWNER_INST) begin
            inst_data_nxt = i_MemRdData;
            inst_ack_nxt  = 1'b1;
          end else begin
            data_ack_nxt = 1'b1;
            // The latched write strobe doubles as the store flag; stores
            // leave the load data register untouched.
            if (!o_MemWrEnable) rd_data_nxt = i_MemRdData;
          end
        end
      end
      ARB_RESP: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      state         <= ARB_IDLE;
      owner         <= OWNER_INST;
      o_MemAddr     <= '0;
      o_MemWrData   <= '0;
      o_MemWrEnable <= 1'b0;
      o_InstData    <= DATA_WIDTH'(INST_NOP);
      o_DataRdData  <= '0;
      o_InstAck     <= 1'b0;
      o_DataAck     <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_nxt;
      o_MemAddr     <= addr_nxt;
      o_MemWrData   <= wdata_nxt;
      o_MemWrEnable <= we_nxt;
      o_InstData    <= inst_data_nxt;
      o_DataRdData  <= rd_data_nxt;
      o_InstAck     <= inst_ack_nxt;
      o_DataAck     <= data_ack_nxt;
    end
  end

endmodule
